// File: rtl/apb_master_ctrl_if.sv
// Command/response and APB bus signals for apb_master_ctrl.
// The master modport is the controller; the slave modport is the far side
// (command source, response sink and the two memory slaves).
interface apb_master_ctrl_if #(
    parameter int ADD_WIDTH = 9,
    parameter int WIDTH     = 32
);
    // command / response
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_write;
    logic [ADD_WIDTH-1:0] cmd_addr;
    logic [WIDTH-1:0]     cmd_wdata;
    logic                 rsp_valid;
    logic [WIDTH-1:0]     rsp_rdata;
    logic                 rsp_err;

    // APB
    logic                 Psel1;
    logic                 Psel2;
    logic                 Penable;
    logic                 Pwrite;
    logic [ADD_WIDTH-2:0] Paddr;
    logic [WIDTH-1:0]     Pwdata;
    logic [WIDTH-1:0]     Prdata1;
    logic [WIDTH-1:0]     Prdata2;
    logic                 Pready1;
    logic                 Pready2;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  Prdata1, Prdata2, Pready1, Pready2,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output Psel1, Psel2, Penable, Pwrite, Paddr, Pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output Prdata1, Prdata2, Pready1, Pready2,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  Psel1, Psel2, Penable, Pwrite, Paddr, Pwdata
    );
endinterface

// File: rtl/apb_master_ctrl.sv
// Single-master APB controller: one command at a time is turned into an
// APB SETUP/ACCESS transfer to slave 1 (addr MSB = 0) or slave 2 (MSB = 1).
// Read data is taken one cycle after ACCESS completes because the slaves
// register Prdata on the completing edge. A transfer whose Pready does not
// arrive within TIMEOUT ACCESS cycles is aborted with rsp_err.
module apb_master_ctrl #(
    parameter int ADD_WIDTH = 9,
    parameter int WIDTH     = 32,
    parameter int TIMEOUT   = 16
) (
    input  logic            Pclk,
    input  logic            Presetn,
    apb_master_ctrl_if.master bus
);

    // counter only needs to reach TIMEOUT-1
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit TO_EN = (TIMEOUT != 0);

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, RDCAP, RESP} state_t;

    state_t          state, nxt;
    logic            sel;        // latched slave select, 1 = slave 2
    logic            sel_d;      // select as seen by the next cycle
    logic [CW-1:0]   to_cnt;
    logic            accept;
    logic            pready;
    logic            to_hit;
    logic [WIDTH-1:0] prdata;

    assign accept        = (state == IDLE) && bus.cmd_valid;
    assign bus.cmd_ready = (state == IDLE);
    assign sel_d         = accept ? bus.cmd_addr[ADD_WIDTH-1] : sel;
    assign pready        = sel ? bus.Pready2 : bus.Pready1;
    assign prdata        = sel ? bus.Prdata2 : bus.Prdata1;
    assign to_hit        = TO_EN && !pready && (to_cnt == TO_LAST);

    // state register
    always_ff @(posedge Pclk or negedge Presetn) begin
        if (!Presetn) state <= IDLE;
        else          state <= nxt;
    end

    // next-state decode
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (bus.cmd_valid) nxt = SETUP;
            SETUP:   nxt = ACCESS;
            ACCESS: begin
                if (pready)      nxt = bus.Pwrite ? RESP : RDCAP;
                else if (to_hit) nxt = RESP;
            end
            RDCAP:   nxt = RESP;
            RESP:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // registered bus/response outputs, driven from the next state so they
    // line up with the state they belong to
    always_ff @(posedge Pclk or negedge Presetn) begin
        if (!Presetn) begin
            sel           <= 1'b0;
            to_cnt        <= '0;
            bus.Psel1     <= 1'b0;
            bus.Psel2     <= 1'b0;
            bus.Penable   <= 1'b0;
            bus.Pwrite    <= 1'b0;
            bus.Paddr     <= '0;
            bus.Pwdata    <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            // command fields go straight onto the bus and hold through IDLE
            if (accept) begin
                sel        <= bus.cmd_addr[ADD_WIDTH-1];
                bus.Paddr  <= bus.cmd_addr[ADD_WIDTH-2:0];
                bus.Pwrite <= bus.cmd_write;
                bus.Pwdata <= bus.cmd_wdata;
            end

            if (nxt == SETUP)
                to_cnt <= '0;
            else if (state == ACCESS && !pready)
                to_cnt <= to_cnt + 1'b1;

            bus.Psel1     <= (nxt == SETUP || nxt == ACCESS) && !sel_d;
            bus.Psel2     <= (nxt == SETUP || nxt == ACCESS) &&  sel_d;
            bus.Penable   <= (nxt == ACCESS);

            bus.rsp_valid <= (nxt == RESP);
            bus.rsp_err   <= (state == ACCESS) && to_hit;
            // only a completed read loads data; everything else leaves 0
            bus.rsp_rdata <= (state == RDCAP) ? prdata : '0;
        end
    end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl with two behavioural APB memory slaves.
module tb_apb_master_ctrl;

    logic Pclk = 1'b0;
    logic Presetn = 1'b0;
    always #5 Pclk = ~Pclk;

    apb_master_ctrl_if #(.ADD_WIDTH(9), .WIDTH(32)) bus ();

    apb_master_ctrl #(.ADD_WIDTH(9), .WIDTH(32), .TIMEOUT(4)) dut (
        .Pclk    (Pclk),
        .Presetn (Presetn),
        .bus     (bus)
    );

    // ---------------- slave models ----------------
    logic [31:0] mem1 [256] = '{default: 32'h0};
    logic [31:0] mem2 [256] = '{default: 32'h0};
    logic [7:0]  wait1 = 8'd0;
    logic [7:0]  wait2 = 8'd0;
    logic [7:0]  acc_cnt = 8'd0;

    assign bus.Pready1 = (acc_cnt >= wait1);
    assign bus.Pready2 = (acc_cnt >= wait2);

    always @(posedge Pclk) begin
        acc_cnt <= bus.Penable ? acc_cnt + 8'd1 : 8'd0;
        if (bus.Psel1 && bus.Penable && bus.Pready1) begin
            if (bus.Pwrite) mem1[bus.Paddr] <= bus.Pwdata;
            else            bus.Prdata1 <= mem1[bus.Paddr];
        end
        if (bus.Psel2 && bus.Penable && bus.Pready2) begin
            if (bus.Pwrite) mem2[bus.Paddr] <= bus.Pwdata;
            else            bus.Prdata2 <= mem2[bus.Paddr];
        end
    end

    // ---------------- bus monitors ----------------
    int          viol = 0;
    int          psel2_seen = 0;
    int          pen_cycles = 0;
    int          acc_total = 0;
    logic [7:0]  paddr2 = 8'h0;

    always @(negedge Pclk) begin
        if ((bus.cmd_ready || bus.rsp_valid) && (bus.Psel1 || bus.Psel2 || bus.Penable))
            viol <= viol + 1;
        if (bus.Penable && !(bus.Psel1 ^ bus.Psel2))
            viol <= viol + 1;
        if (bus.Psel2)                psel2_seen <= psel2_seen + 1;
        if (bus.Penable)              pen_cycles <= pen_cycles + 1;
        if (bus.Psel2 && !bus.Penable) paddr2 <= bus.Paddr;
    end

    always @(posedge Pclk)
        if (bus.cmd_valid && bus.cmd_ready) acc_total <= acc_total + 1;

    // ---------------- checking ----------------
    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input logic w, input logic [8:0] a, input logic [31:0] d,
                           output logic [31:0] rd, output logic er, output int lat);
        int n;
        n = 0;
        @(negedge Pclk);
        while (!bus.cmd_ready && n < 100) begin
            @(negedge Pclk);
            n++;
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        @(posedge Pclk);
        #1 bus.cmd_valid = 1'b0;
        lat = -1;
        rd  = 32'hx;
        er  = 1'bx;
        for (int i = 1; i <= 100; i++) begin
            @(negedge Pclk);
            if (bus.rsp_valid) begin
                lat = i;
                rd  = bus.rsp_rdata;
                er  = bus.rsp_err;
                break;
            end
        end
    endtask

    logic [8:0]  b2b_addr [4] = '{9'h010, 9'h111, 9'h0FF, 9'h100};
    logic [31:0] b2b_data [4] = '{32'h0102_0304, 32'hF00D_CAFE, 32'hFFFF_FFFF, 32'h8000_0001};

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          snap, snap2, n;
        logic        rsp_any;
        logic        w;
        logic [8:0]  a;
        logic [31:0] d;

        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;

        // reset state
        repeat (3) @(negedge Pclk);
        chk("rst_psel1",   32'(bus.Psel1),     32'd0);
        chk("rst_psel2",   32'(bus.Psel2),     32'd0);
        chk("rst_penable", 32'(bus.Penable),   32'd0);
        chk("rst_pwrite",  32'(bus.Pwrite),    32'd0);
        chk("rst_paddr",   32'(bus.Paddr),     32'd0);
        chk("rst_pwdata",  bus.Pwdata,         32'd0);
        chk("rst_rsp",     32'({bus.rsp_valid, bus.rsp_err}), 32'd0);
        chk("rst_rdata",   bus.rsp_rdata,      32'd0);
        Presetn = 1'b1;
        @(negedge Pclk);
        chk("rst_ready",   32'(bus.cmd_ready), 32'd1);

        // write then read, slave 1
        snap = psel2_seen;
        run_cmd(1'b1, 9'h005, 32'hDEAD_BEEF, rd, er, lat);
        chk("t1_wr_lat",   32'(lat), 32'd3);
        chk("t1_wr_err",   32'(er),  32'd0);
        chk("t1_wr_rdata", rd,       32'd0);
        @(negedge Pclk);
        chk("t1_pulse",    32'(bus.rsp_valid), 32'd0);
        run_cmd(1'b0, 9'h005, 32'h0, rd, er, lat);
        chk("t1_rd_lat",   32'(lat), 32'd4);
        chk("t1_rd_data",  rd,       32'hDEAD_BEEF);
        chk("t1_rd_err",   32'(er),  32'd0);
        @(negedge Pclk);
        chk("t1_rdata_clr", bus.rsp_rdata, 32'd0);
        chk("t1_no_psel2", 32'(psel2_seen - snap), 32'd0);

        // slave decode
        run_cmd(1'b1, 9'h105, 32'h1234_5678, rd, er, lat);
        chk("t2_wr2_lat",  32'(lat),    32'd3);
        chk("t2_paddr2",   32'(paddr2), 32'h05);
        run_cmd(1'b1, 9'h005, 32'hAAAA_5555, rd, er, lat);
        run_cmd(1'b0, 9'h105, 32'h0, rd, er, lat);
        chk("t2_rd2",      rd, 32'h1234_5678);
        run_cmd(1'b0, 9'h005, 32'h0, rd, er, lat);
        chk("t2_rd1",      rd, 32'hAAAA_5555);

        // timeout: slave 1 stalls, slave 2 ready (must be ignored)
        wait1 = 8'd255;
        wait2 = 8'd0;
        snap = pen_cycles;
        run_cmd(1'b1, 9'h00A, 32'h0000_0001, rd, er, lat);
        chk("t3_wr_lat",   32'(lat), 32'd6);
        chk("t3_wr_err",   32'(er),  32'd1);
        chk("t3_wr_rdata", rd,       32'd0);
        chk("t3_acc_cyc",  32'(pen_cycles - snap), 32'd4);
        @(negedge Pclk);
        chk("t3_idle",     32'({bus.cmd_ready, bus.rsp_valid, bus.rsp_err}), 32'b100);
        run_cmd(1'b0, 9'h00A, 32'h0, rd, er, lat);
        chk("t3_rd_err",   32'(er),  32'd1);
        chk("t3_rd_rdata", rd,       32'd0);
        wait1 = 8'd0;
        run_cmd(1'b0, 9'h005, 32'h0, rd, er, lat);
        chk("t3_recover",  rd,       32'hAAAA_5555);
        chk("t3_rec_err",  32'(er),  32'd0);

        // wait states: Pready on 3rd ACCESS cycle of a read
        wait2 = 8'd2;
        snap = pen_cycles;
        run_cmd(1'b0, 9'h105, 32'h0, rd, er, lat);
        chk("t4_lat",      32'(lat), 32'd6);
        chk("t4_acc_cyc",  32'(pen_cycles - snap), 32'd3);
        chk("t4_data",     rd,       32'h1234_5678);
        wait2 = 8'd0;

        // reset during ACCESS of a write
        wait1 = 8'd255;
        snap2 = acc_total;
        @(negedge Pclk);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 9'h007;
        bus.cmd_wdata = 32'hCAFE_F00D;
        @(posedge Pclk);
        #1 bus.cmd_valid = 1'b0;
        @(negedge Pclk);
        @(negedge Pclk);
        chk("t5_in_access", 32'({bus.Psel1, bus.Penable, bus.Pwrite}), 32'b111);
        #2 Presetn = 1'b0;
        #1;
        chk("t5_async_sel", 32'({bus.Psel1, bus.Psel2, bus.Penable}), 32'd0);
        chk("t5_async_pw",  32'(bus.Pwrite), 32'd0);
        chk("t5_async_pa",  32'(bus.Paddr),  32'd0);
        chk("t5_async_pd",  bus.Pwdata,      32'd0);
        rsp_any = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Pclk);
            rsp_any = rsp_any | bus.rsp_valid;
        end
        Presetn = 1'b1;
        @(negedge Pclk);
        rsp_any = rsp_any | bus.rsp_valid;
        chk("t5_no_rsp",    32'(rsp_any),       32'd0);
        chk("t5_ready",     32'(bus.cmd_ready), 32'd1);
        chk("t5_one_acc",   32'(acc_total - snap2), 32'd1);
        wait1 = 8'd0;
        run_cmd(1'b0, 9'h005, 32'h0, rd, er, lat);
        chk("t5_rd",        rd, 32'hAAAA_5555);
        run_cmd(1'b0, 9'h007, 32'h0, rd, er, lat);
        chk("t5_unwritten", rd, 32'h0);

        // back-to-back with cmd_valid held high
        snap  = viol;
        snap2 = acc_total;
        bus.cmd_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            w = (k % 2 == 0);
            a = b2b_addr[k/2];
            d = b2b_data[k/2];
            bus.cmd_write = w;
            bus.cmd_addr  = a;
            bus.cmd_wdata = d;
            n = 1;
            @(negedge Pclk);
            while (!bus.cmd_ready && n < 20) begin
                @(negedge Pclk);
                n++;
            end
            if (k > 0) chk("b2b_gap", 32'(n), 32'd1);
            @(posedge Pclk);
            // junk command left pending while busy; must never be taken
            #1;
            bus.cmd_write = 1'b1;
            bus.cmd_wdata = 32'hBAD0_0000 | 32'(k);
            lat = -1;
            rd  = 32'hx;
            for (int i = 1; i <= 20; i++) begin
                @(negedge Pclk);
                if (bus.rsp_valid) begin
                    lat = i;
                    rd  = bus.rsp_rdata;
                    break;
                end
            end
            chk("b2b_lat", 32'(lat), w ? 32'd3 : 32'd4);
            if (!w) chk("b2b_data", rd, d);
        end
        bus.cmd_valid = 1'b0;
        repeat (2) @(negedge Pclk);
        chk("b2b_accepts", 32'(acc_total - snap2), 32'd8);
        chk("b2b_bus_idle", 32'(viol - snap), 32'd0);
        chk("all_bus_idle", 32'(viol), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // hard stop in case a DUT hang escapes the per-wait bounds
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
